// File: rtl/operand_stage_pkg.sv
// Shared definitions for the operand (register-read) stage in front of the
// 16-bit ALU: datapath widths, ALU control encodings, handshake state
// encoding and the immediate-extend helper.
package operand_stage_pkg;

    localparam int WIDTH = 16;          // datapath width
    localparam int AW    = 4;           // register address width
    localparam int NREGS = 2 ** AW;     // number of general registers
    localparam int IMMW  = 8;           // immediate field width
    localparam int CONTW = 4;           // ALU control width

    // ALU operation select carried in alucont[2:0]
    typedef enum logic [2:0] {
        ALU_AND   = 3'b000,
        ALU_OR    = 3'b001,
        ALU_ADD   = 3'b010,
        ALU_SLT   = 3'b011,
        ALU_SHIFT = 3'b100
    } alu_op_e;

    // alucont[3] selects carry-in usage / subtract in the ALU
    localparam int ALU_CIN_SUB_BIT = 3;

    // Output buffer occupancy
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } opst_state_e;

    // Widen the immediate to the datapath: sign bit replicated when
    // sign_ext is set, zeros otherwise.
    function automatic logic [WIDTH-1:0] ext_imm(input logic [IMMW-1:0] imm,
                                                 input logic            sign_ext);
        logic [WIDTH-1:0] w_ext;
        w_ext = {{(WIDTH-IMMW){sign_ext & imm[IMMW-1]}}, imm};
        return w_ext;
    endfunction

endpackage

// File: rtl/operand_stage_if.sv
// Bundle of the operand stage's instruction handshake, ALU operand bus and
// writeback port. master = upstream/ALU side, slave = operand_stage.
interface operand_stage_if;
    import operand_stage_pkg::*;

    // instruction input handshake
    logic              in_valid;
    logic              in_ready;
    logic [AW-1:0]     in_rdest;
    logic [AW-1:0]     in_rsrc;
    logic [IMMW-1:0]   in_imm;
    logic              in_use_imm;
    logic              in_sign_ext;
    logic [CONTW-1:0]  in_alucont;

    // ALU operand output handshake
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  alu_in1;
    logic [WIDTH-1:0]  alu_in2;
    logic [CONTW-1:0]  alu_cont;
    logic              alu_cin;
    logic [AW-1:0]     out_rdest;

    // writeback from the ALU
    logic              wb_en;
    logic [AW-1:0]     wb_addr;
    logic [WIDTH-1:0]  wb_data;
    logic              wb_c_en;
    logic              wb_c;

    modport master (
        output in_valid, in_rdest, in_rsrc, in_imm, in_use_imm, in_sign_ext,
               in_alucont, out_ready, wb_en, wb_addr, wb_data, wb_c_en, wb_c,
        input  in_ready, out_valid, alu_in1, alu_in2, alu_cont, alu_cin,
               out_rdest
    );

    modport slave (
        input  in_valid, in_rdest, in_rsrc, in_imm, in_use_imm, in_sign_ext,
               in_alucont, out_ready, wb_en, wb_addr, wb_data, wb_c_en, wb_c,
        output in_ready, out_valid, alu_in1, alu_in2, alu_cont, alu_cin,
               out_rdest
    );

endinterface

// File: rtl/operand_stage_regfile_2r1w.sv
// General register file: two asynchronous read ports, one synchronous write
// port, asynchronous active-low clear of every entry. No entry is hardwired.
module regfile_2r1w #(
    parameter int W  = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr1,
    output logic [W-1:0]  o_rdata1,
    input  logic [AW-1:0] i_raddr2,
    output logic [W-1:0]  o_rdata2
);

    localparam int N = 2 ** AW;

    logic [W-1:0] r_mem [N];

    // Storage: cleared on reset, one write per clock when enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Reads see the stored contents; a same-cycle write is not forwarded here
    assign o_rdata1 = r_mem[i_raddr1];
    assign o_rdata2 = r_mem[i_raddr2];

endmodule

// File: rtl/operand_stage.sv
// Register-file read stage feeding the 16-bit ALU. Accepts decoded
// instructions over valid/ready, reads two operands (or one plus an extended
// immediate) and presents them registered with control and carry-in. Owns
// the register file and the carry flag; results return on the writeback port.
// Optional feature macro: OPSTAGE_WB_BYPASS_EN -- forwards same-cycle
// writeback into accepted operands and patches held operands in place.
module operand_stage
    import operand_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    operand_stage_if.slave  bus
);

    // handshake / occupancy
    opst_state_e       r_state;
    opst_state_e       w_state_nxt;
    logic              w_in_ready;
    logic              w_accept;

    // register file read data and selected operands
    logic [WIDTH-1:0]  w_rf_rd1;
    logic [WIDTH-1:0]  w_rf_rd2;
    logic [WIDTH-1:0]  w_op1;
    logic [WIDTH-1:0]  w_op2;
    logic              w_cin;

    // architectural carry flag
    logic              r_carry;

    // registered ALU-facing outputs
    logic [WIDTH-1:0]  r_alu_in1;
    logic [WIDTH-1:0]  r_alu_in2;
    logic [CONTW-1:0]  r_alu_cont;
    logic              r_alu_cin;
    logic [AW-1:0]     r_out_rdest;

`ifdef OPSTAGE_WB_BYPASS_EN
    // source tag of the held instruction, needed to patch operand 2
    logic [AW-1:0]     r_rsrc;
    logic              r_use_imm;
`endif

    regfile_2r1w #(
        .W  (WIDTH),
        .AW (AW)
    ) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_we     (bus.wb_en),
        .i_waddr  (bus.wb_addr),
        .i_wdata  (bus.wb_data),
        .i_raddr1 (bus.in_rdest),
        .o_rdata1 (w_rf_rd1),
        .i_raddr2 (bus.in_rsrc),
        .o_rdata2 (w_rf_rd2)
    );

    // A new instruction may enter when the buffer is empty or being drained
    assign w_in_ready   = (r_state == ST_EMPTY) || bus.out_ready;
    assign w_accept     = bus.in_valid && w_in_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == ST_FULL);
    assign bus.alu_in1   = r_alu_in1;
    assign bus.alu_in2   = r_alu_in2;
    assign bus.alu_cont  = r_alu_cont;
    assign bus.alu_cin   = r_alu_cin;
    assign bus.out_rdest = r_out_rdest;

    // Occupancy state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Occupancy next state: fill on accept, drain on consume without refill
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (bus.out_ready && !w_accept) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Carry flag, written by the ALU independently of the handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry <= 1'b0;
        end else if (bus.wb_c_en) begin
            r_carry <= bus.wb_c;
        end
    end

    // Operand selection for the instruction presented this cycle
    always_comb begin
        w_op1 = w_rf_rd1;
        w_op2 = bus.in_use_imm ? ext_imm(bus.in_imm, bus.in_sign_ext) : w_rf_rd2;
        w_cin = r_carry;
`ifdef OPSTAGE_WB_BYPASS_EN
        // write-through: a same-cycle writeback wins over the stored value
        if (bus.wb_en && (bus.wb_addr == bus.in_rdest)) begin
            w_op1 = bus.wb_data;
        end
        if (bus.wb_en && !bus.in_use_imm && (bus.wb_addr == bus.in_rsrc)) begin
            w_op2 = bus.wb_data;
        end
        if (bus.wb_c_en) begin
            w_cin = bus.wb_c;
        end
`endif
    end

    // Output operand registers: load on accept, otherwise hold (or patch)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_in1   <= '0;
            r_alu_in2   <= '0;
            r_alu_cont  <= '0;
            r_alu_cin   <= 1'b0;
            r_out_rdest <= '0;
`ifdef OPSTAGE_WB_BYPASS_EN
            r_rsrc      <= '0;
            r_use_imm   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_alu_in1   <= w_op1;
            r_alu_in2   <= w_op2;
            r_alu_cont  <= bus.in_alucont;
            r_alu_cin   <= w_cin;
            r_out_rdest <= bus.in_rdest;
`ifdef OPSTAGE_WB_BYPASS_EN
            r_rsrc      <= bus.in_rsrc;
            r_use_imm   <= bus.in_use_imm;
`endif
        end
`ifdef OPSTAGE_WB_BYPASS_EN
        else if ((r_state == ST_FULL) && !bus.out_ready) begin
            // stalled operands track writebacks to their source registers
            if (bus.wb_en && (bus.wb_addr == r_out_rdest)) begin
                r_alu_in1 <= bus.wb_data;
            end
            if (bus.wb_en && !r_use_imm && (bus.wb_addr == r_rsrc)) begin
                r_alu_in2 <= bus.wb_data;
            end
            if (bus.wb_c_en) begin
                r_alu_cin <= bus.wb_c;
            end
        end
`endif
    end

endmodule

// File: tb/tb_operand_stage.sv
// Self-checking bench for operand_stage: directed scenarios plus a random
// run compared against a behavioural model of the register file, carry flag
// and single-entry output buffer.
module tb_operand_stage;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    operand_stage_if bus();

    operand_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // behavioural model state
    logic [15:0] m_rf [16];
    logic        m_c;
    logic        m_valid;
    logic [15:0] m_in1;
    logic [15:0] m_in2;
    logic [3:0]  m_cont;
    logic        m_cin;
    logic [3:0]  m_rdest;
    logic [3:0]  m_rsrc;
    logic        m_use_imm;

    function automatic logic [15:0] m_ext(input logic [7:0] imm, input logic sx);
        int v;
        v = int'(imm);
        if (sx && v >= 128) v = v - 256;
        return v[15:0];
    endfunction

    function automatic logic [15:0] m_read(input logic [3:0] a);
        logic [15:0] v;
        v = m_rf[a];
`ifdef OPSTAGE_WB_BYPASS_EN
        if (bus.wb_en && bus.wb_addr == a) v = bus.wb_data;
`endif
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_rf[i] = 16'h0;
        m_c = 0; m_valid = 0; m_in1 = 0; m_in2 = 0; m_cont = 0;
        m_cin = 0; m_rdest = 0; m_rsrc = 0; m_use_imm = 0;
    endtask

    task automatic idle();
        bus.in_valid = 0; bus.in_rdest = 0; bus.in_rsrc = 0; bus.in_imm = 0;
        bus.in_use_imm = 0; bus.in_sign_ext = 0; bus.in_alucont = 0;
        bus.out_ready = 1; bus.wb_en = 0; bus.wb_addr = 0; bus.wb_data = 0;
        bus.wb_c_en = 0; bus.wb_c = 0;
    endtask

    task automatic drive(input logic [3:0] rd, input logic [3:0] rs,
                         input logic [7:0] imm, input logic ui, input logic sx,
                         input logic [3:0] cont);
        bus.in_valid = 1; bus.in_rdest = rd; bus.in_rsrc = rs; bus.in_imm = imm;
        bus.in_use_imm = ui; bus.in_sign_ext = sx; bus.in_alucont = cont;
    endtask

    // Advance one clock, updating the model from the inputs seen at the edge
    task automatic tick();
        logic acc, nv;
        acc = bus.in_valid && (!m_valid || bus.out_ready);
        nv  = acc ? 1'b1 : (bus.out_ready ? 1'b0 : m_valid);
        if (acc) begin
            m_in1     = m_read(bus.in_rdest);
            m_in2     = bus.in_use_imm ? m_ext(bus.in_imm, bus.in_sign_ext)
                                       : m_read(bus.in_rsrc);
            m_cont    = bus.in_alucont;
            m_cin     = m_c;
`ifdef OPSTAGE_WB_BYPASS_EN
            if (bus.wb_c_en) m_cin = bus.wb_c;
`endif
            m_rdest   = bus.in_rdest;
            m_rsrc    = bus.in_rsrc;
            m_use_imm = bus.in_use_imm;
        end
`ifdef OPSTAGE_WB_BYPASS_EN
        else if (m_valid && !bus.out_ready) begin
            if (bus.wb_en && bus.wb_addr == m_rdest) m_in1 = bus.wb_data;
            if (bus.wb_en && !m_use_imm && bus.wb_addr == m_rsrc) m_in2 = bus.wb_data;
            if (bus.wb_c_en) m_cin = bus.wb_c;
        end
`endif
        if (bus.wb_en) m_rf[bus.wb_addr] = bus.wb_data;
        if (bus.wb_c_en) m_c = bus.wb_c;
        m_valid = nv;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        bus.wb_en = 1; bus.wb_addr = 4'd5; bus.wb_data = 16'hAAAA;
        drive(4'd5, 4'd5, 8'h00, 0, 0, 4'b0011);
        bus.out_ready = 0;
        tick();
        idle();
        bus.out_ready = 0;
        #2;
        rst_n = 0;
        #1;
        model_reset();
        n_total++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else n_pass++;
        n_total++;
        if ({bus.alu_in1, bus.alu_in2, bus.alu_cont, bus.alu_cin, bus.out_rdest} !== 41'h0)
            $display("FAIL reset_outputs got in1=%h in2=%h cont=%h cin=%b rd=%h want all 0",
                     bus.alu_in1, bus.alu_in2, bus.alu_cont, bus.alu_cin, bus.out_rdest);
        else n_pass++;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        idle();
        drive(4'd5, 4'd5, 8'h00, 0, 0, 4'b0000);
        tick();
        n_total++;
        if (bus.alu_in1 !== 16'h0000) $display("FAIL reset_r5_cleared got %h want 0000", bus.alu_in1); else n_pass++;
        n_total++;
        if (bus.out_valid !== 1'b1) $display("FAIL reset_first_accept got %b want 1", bus.out_valid); else n_pass++;
        idle();
        tick();
    endtask

    task automatic test_basic_read();
        idle();
        bus.wb_en = 1; bus.wb_addr = 4'd3; bus.wb_data = 16'h1234;
        tick();
        bus.wb_addr = 4'd7; bus.wb_data = 16'h00FF;
        tick();
        idle();
        drive(4'd3, 4'd7, 8'h00, 0, 0, 4'b0010);
        tick();
        n_total++;
        if (bus.alu_in1 !== 16'h1234) $display("FAIL basic_in1 got %h want 1234", bus.alu_in1); else n_pass++;
        n_total++;
        if (bus.alu_in2 !== 16'h00FF) $display("FAIL basic_in2 got %h want 00ff", bus.alu_in2); else n_pass++;
        n_total++;
        if (bus.alu_cont !== 4'b0010 || bus.out_rdest !== 4'd3)
            $display("FAIL basic_cont_rdest got %b/%h want 0010/3", bus.alu_cont, bus.out_rdest);
        else n_pass++;
        drive(4'd3, 4'd3, 8'h00, 0, 0, 4'b0001);
        tick();
        n_total++;
        if (bus.alu_in1 !== 16'h1234 || bus.alu_in2 !== 16'h1234)
            $display("FAIL same_reg got %h/%h want 1234/1234", bus.alu_in1, bus.alu_in2);
        else n_pass++;
        idle();
        tick();
    endtask

    task automatic test_immediate();
        idle();
        drive(4'd7, 4'd0, 8'hF0, 1, 1, 4'b0010);
        tick();
        n_total++;
        if (bus.alu_in2 !== 16'hFFF0) $display("FAIL imm_sext got %h want fff0", bus.alu_in2); else n_pass++;
        n_total++;
        if (bus.alu_in1 !== 16'h00FF) $display("FAIL imm_in1 got %h want 00ff", bus.alu_in1); else n_pass++;
        drive(4'd7, 4'd0, 8'hF0, 1, 0, 4'b0010);
        tick();
        n_total++;
        if (bus.alu_in2 !== 16'h00F0) $display("FAIL imm_zext got %h want 00f0", bus.alu_in2); else n_pass++;
        drive(4'd7, 4'd0, 8'h70, 1, 1, 4'b0010);
        tick();
        n_total++;
        if (bus.alu_in2 !== 16'h0070) $display("FAIL imm_sext_pos got %h want 0070", bus.alu_in2); else n_pass++;
        idle();
        tick();
    endtask

    task automatic test_backpressure();
        idle();
        bus.wb_en = 1; bus.wb_addr = 4'd1; bus.wb_data = 16'h1111;
        tick();
        idle();
        drive(4'd1, 4'd0, 8'h12, 1, 0, 4'b0100);
        bus.out_ready = 0;
        tick();
        drive(4'd3, 4'd7, 8'h00, 0, 0, 4'b0001);
        bus.out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++;
            if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready cyc%0d got %b want 0", i, bus.in_ready); else n_pass++;
            tick();
            n_total++;
            if (bus.out_valid !== 1'b1 || bus.alu_in1 !== 16'h1111 || bus.alu_in2 !== 16'h0012 || bus.alu_cont !== 4'b0100)
                $display("FAIL bp_hold cyc%0d got v=%b %h %h %b want 1 1111 0012 0100",
                         i, bus.out_valid, bus.alu_in1, bus.alu_in2, bus.alu_cont);
            else n_pass++;
        end
        bus.out_ready = 1;
        #1;
        n_total++;
        if (bus.in_ready !== 1'b1) $display("FAIL bp_release_ready got %b want 1", bus.in_ready); else n_pass++;
        tick();
        n_total++;
        if (bus.out_valid !== 1'b1 || bus.alu_in1 !== 16'h1234 || bus.alu_in2 !== 16'h00FF || bus.alu_cont !== 4'b0001)
            $display("FAIL bp_next got v=%b %h %h %b want 1 1234 00ff 0001",
                     bus.out_valid, bus.alu_in1, bus.alu_in2, bus.alu_cont);
        else n_pass++;
        idle();
        tick();
        n_total++;
        if (bus.out_valid !== 1'b0) $display("FAIL bp_drain got %b want 0", bus.out_valid); else n_pass++;
    endtask

    task automatic test_bypass();
        logic [15:0] exp_acc, exp_hold;
`ifdef OPSTAGE_WB_BYPASS_EN
        exp_acc = 16'hBEEF; exp_hold = 16'h0001;
`else
        exp_acc = 16'h5555; exp_hold = 16'h5555;
`endif
        idle();
        bus.wb_en = 1; bus.wb_addr = 4'd2; bus.wb_data = 16'h5555;
        tick();
        idle();
        bus.wb_en = 1; bus.wb_addr = 4'd2; bus.wb_data = 16'hBEEF;
        drive(4'd2, 4'd0, 8'h00, 1, 0, 4'b0010);
        bus.out_ready = 0;
        tick();
        n_total++;
        if (bus.alu_in1 !== exp_acc) $display("FAIL wb_same_cycle got %h want %h", bus.alu_in1, exp_acc); else n_pass++;
        idle();
        bus.out_ready = 0;
        bus.wb_en = 1; bus.wb_addr = 4'd2; bus.wb_data = 16'h0001;
        tick();
        n_total++;
        if (bus.alu_in1 !== exp_hold) $display("FAIL wb_hold got %h want %h", bus.alu_in1, exp_hold); else n_pass++;
        idle();
        tick();
        drive(4'd2, 4'd2, 8'h00, 0, 0, 4'b0000);
        tick();
        n_total++;
        if (bus.alu_in1 !== 16'h0001 || bus.alu_in2 !== 16'h0001)
            $display("FAIL wb_reread got %h/%h want 0001/0001", bus.alu_in1, bus.alu_in2);
        else n_pass++;
        idle();
        tick();
    endtask

    task automatic test_carry();
        idle();
        bus.wb_c_en = 1; bus.wb_c = 1;
        tick();
        idle();
        drive(4'd0, 4'd1, 8'h00, 0, 0, 4'b1010);
        tick();
        n_total++;
        if (bus.alu_cin !== 1'b1) $display("FAIL carry_set got %b want 1", bus.alu_cin); else n_pass++;
        idle();
        tick();
        rst_n = 0;
        #1;
        model_reset();
        n_total++;
        if (bus.alu_cin !== 1'b0) $display("FAIL carry_reset got %b want 0", bus.alu_cin); else n_pass++;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        drive(4'd0, 4'd1, 8'h00, 0, 0, 4'b1010);
        tick();
        n_total++;
        if (bus.alu_cin !== 1'b0) $display("FAIL carry_after_reset got %b want 0", bus.alu_cin); else n_pass++;
        idle();
        tick();
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            bus.in_valid    = ($urandom_range(0, 3) != 0);
            bus.in_rdest    = 4'($urandom_range(0, 15));
            bus.in_rsrc     = 4'($urandom_range(0, 15));
            bus.in_imm      = 8'($urandom_range(0, 255));
            bus.in_use_imm  = 1'($urandom_range(0, 1));
            bus.in_sign_ext = 1'($urandom_range(0, 1));
            bus.in_alucont  = 4'($urandom_range(0, 15));
            bus.out_ready   = ($urandom_range(0, 2) != 0);
            bus.wb_en       = 1'($urandom_range(0, 1));
            bus.wb_addr     = 4'($urandom_range(0, 15));
            bus.wb_data     = 16'($urandom_range(0, 65535));
            bus.wb_c_en     = ($urandom_range(0, 3) == 0);
            bus.wb_c        = 1'($urandom_range(0, 1));
            #1;
            n_total++;
            if (bus.in_ready !== (!m_valid || bus.out_ready)) begin
                if (errs < 10) $display("FAIL rand_in_ready i=%0d got %b want %b", i, bus.in_ready, (!m_valid || bus.out_ready));
                errs++;
            end else n_pass++;
            tick();
            n_total++;
            if (bus.out_valid !== m_valid ||
                (m_valid && {bus.alu_in1, bus.alu_in2, bus.alu_cont, bus.alu_cin, bus.out_rdest}
                            !== {m_in1, m_in2, m_cont, m_cin, m_rdest})) begin
                if (errs < 10)
                    $display("FAIL rand_out i=%0d got v=%b %h %h %h %b %h want v=%b %h %h %h %b %h", i,
                             bus.out_valid, bus.alu_in1, bus.alu_in2, bus.alu_cont, bus.alu_cin, bus.out_rdest,
                             m_valid, m_in1, m_in2, m_cont, m_cin, m_rdest);
                errs++;
            end else n_pass++;
        end
        idle();
        tick();
    endtask

    initial begin
        idle();
        model_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        @(posedge clk);
        #1;
        test_reset();
        test_basic_read();
        test_immediate();
        test_backpressure();
        test_bypass();
        test_carry();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/operand_stage.md
Name: operand_stage

Overview:
- Register-file read stage sitting directly upstream of the 16-bit ALU.
- Accepts decoded instructions (Rdest, Rsrc/immediate, ALU control) over a valid/ready handshake, reads a 16x16 register file, and presents a registered operand pair, control and carry-in to the ALU.
- Owns the register file and the carry flag; ALU results and cOut return via a writeback port.

Parameters:
- WIDTH, 16, datapath width.
- NREGS, 16, number of general registers.
- AW, 4, register address width; NREGS = 2**AW.
- IMMW, 8, immediate field width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept this cycle.
- in_rdest  in  AW  destination/first-operand register.
- in_rsrc  in  AW  source register.
- in_imm  in  IMMW  immediate field.
- in_use_imm  in  1  1: operand 2 is the immediate.
- in_sign_ext  in  1  1: sign-extend the immediate; 0: zero-extend.
- in_alucont  in  4  ALU control, passed through.
- out_valid  out  1  ALU operands valid.
- out_ready  in  1  downstream consumes this cycle.
- alu_in1  out  WIDTH  R[rdest].
- alu_in2  out  WIDTH  R[rsrc] or extended immediate.
- alu_cont  out  4  latched in_alucont.
- alu_cin  out  1  latched carry flag.
- out_rdest  out  AW  latched rdest, for writeback tagging.
- wb_en  in  1  register write enable.
- wb_addr  in  AW  write address.
- wb_data  in  WIDTH  write data.
- wb_c_en  in  1  carry flag write enable.
- wb_c  in  1  new carry value.

Behaviour:
- Reset (async, rst_n=0): all registers, the carry flag, out_valid, alu_in1, alu_in2, alu_cont, alu_cin and out_rdest go to 0; state is EMPTY. Reset mid-transfer discards the buffered instruction.
- States:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
  - EMPTY→FULL on accept.
  - FULL→EMPTY on out_ready with no accept.
  - FULL→FULL on out_ready with accept (back-to-back).
- in_ready = !out_valid || out_ready, combinational. Accept = in_valid && in_ready.
- Latency: 1 cycle from accept to out_valid. Sustained throughput is 1 per cycle.
- On accept, the following are registered:
  - alu_in1 = R[in_rdest].
  - alu_in2 = in_use_imm ? ext(in_imm) : R[in_rsrc].
  - alu_cont = in_alucont.
  - alu_cin = carry flag.
  - out_rdest = in_rdest.
  - ext: sign extension replicates in_imm[IMMW-1]; otherwise upper bits are 0.
- Writeback: R[wb_addr] <= wb_data on a clock edge when wb_en=1. Carry flag <= wb_c when wb_c_en=1. Writeback is independent of the handshake.
- Holding: while FULL and !out_ready, all outputs hold stable, except for the patch rule under the optional feature.
- Same register for both operands (rdest=rsrc): both operands get the identical value.
- No register is hardwired to zero.

Optional Feature:
- Macro OPSTAGE_WB_BYPASS_EN.
- Defined:
  - Write-through: on accept, a same-cycle wb_en with wb_addr matching rdest/rsrc supplies wb_data to the corresponding operand. Same rule applies to wb_c_en → alu_cin.
  - Hold-patch: while FULL and !out_ready, a wb_en matching the latched address updates alu_in1, and alu_in2 when not using the immediate; wb_c_en updates alu_cin.
  - Requires latching rsrc and use_imm internally.
- Undefined:
  - Reads return pre-write register contents and held outputs never change.
  - Upstream must stall dependent instructions itself.

Decomposition:
- Shared package: WIDTH/AW/IMMW defaults, ALU control encodings (AND=000, OR=001, ADD=010, SLT=011, SHIFT=100, bit3=carry-in/sub select), immediate-extend function.
- One natural sub-module: regfile_2r1w (two async read ports, one sync write port, async active-low clear); operand_stage instantiates it.

Test Plan:
- Reset: assert rst_n=0 mid-FULL → out_valid=0, all outputs 0; after release, read R5 → alu_in1=0x0000.
- Basic read: write R3=0x1234, R7=0x00FF; issue rdest=3, rsrc=7, alucont=0010 → next cycle alu_in1=0x1234, alu_in2=0x00FF, alu_cont=0010.
- Immediate: imm=0xF0 with sign_ext=1 → alu_in2=0xFFF0; sign_ext=0 → alu_in2=0x00F0.
- Backpressure: out_ready=0 for 3 cycles → in_ready=0, outputs stable. Then out_ready=1 with in_valid=1 → next instruction appears the following cycle with no bubble.
- Bypass (EN defined): accept rdest=2 while wb_en=1, wb_addr=2, wb_data=0xBEEF → alu_in1=0xBEEF. While held, wb to R2=0x0001 → alu_in1=0x0001. Undefined: alu_in1 keeps the old R2 value.
- Carry: wb_c_en=1, wb_c=1, then issue an instruction → alu_cin=1; after reset → alu_cin=0.
